// File: rtl/ad9364_dac_pkg.sv
// Shared types and helpers for the AD9364 DAC test-pattern generator.
// Pattern encodings, FSM state type and the saturating two's-complement negate.
package ad9364_dac_pkg;

    typedef enum logic [1:0] {
        PAT_CONST  = 2'd0,
        PAT_SQUARE = 2'd1,
        PAT_RAMP   = 2'd2,
        PAT_PRBS   = 2'd3
    } pattern_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // x is a sign-extended w-bit value; the most negative w-bit code maps to the most positive.
    function automatic logic [31:0] sat_neg(input logic [31:0] x, input int unsigned w);
        logic [31:0] min_v;
        min_v = 32'hFFFF_FFFF << (w - 1);
        if (x == min_v) begin
            return ~min_v;
        end
        return 32'd0 - x;
    endfunction

endpackage

// File: rtl/ad9364_dac_pattern_gen_prbs.sv
// PRBS15 (x^15 + x^14 + 1, Fibonacci) sequence source with step, reload and zero-guard.
// The lfsr output is the value in force for the current sample, after any reload.
module ad9364_prbs15 #(
    parameter logic [14:0] SEED = 15'h7FFF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        step,
    input  logic        reload,
    output logic [14:0] lfsr
);

    logic [14:0] lfsr_q;
    logic [14:0] lfsr_d;
    logic [14:0] cur;

    always_comb begin
        // An all-zero register would lock up, so treat it like a reload request.
        cur    = (reload || lfsr_q == 15'd0) ? SEED : lfsr_q;
        lfsr_d = lfsr_q;
        if (step) begin
            lfsr_d = {cur[13:0], cur[14] ^ cur[13]};
        end else if (reload) begin
            lfsr_d = cur;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = cur;

endmodule

// File: rtl/ad9364_dac_pattern_gen.sv
// Test-pattern source feeding the AD9364 interface transmit path: paces dac_valid to the
// word-serialisation cadence and emits constant, square, ramp or PRBS15 samples.
module ad9364_dac_pattern_gen
    import ad9364_dac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter logic [14:0] LFSR_SEED  = 15'h7FFF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic [1:0]            pattern_sel,
    input  logic                  r1_mode,
    input  logic [DATA_WIDTH-1:0] const_i,
    input  logic [DATA_WIDTH-1:0] const_q,
    input  logic [DATA_WIDTH-1:0] ramp_step,
    input  logic [DIV_WIDTH-1:0]  half_period,
    output logic                  dac_valid,
    output logic [DATA_WIDTH-1:0] dac_data_i1,
    output logic [DATA_WIDTH-1:0] dac_data_q1,
    output logic [DATA_WIDTH-1:0] dac_data_i2,
    output logic [DATA_WIDTH-1:0] dac_data_q2,
    output logic                  dac_r1_mode,
    output logic [31:0]           sample_cnt
);

    localparam logic [DATA_WIDTH-1:0] RAMP_OFFSET = DATA_WIDTH'(1) << (DATA_WIDTH - 2);

    logic [1:0]            cad_q, cad_d;
    state_e                state_q, state_d;
    logic                  phase_q, phase_d, phase_cur;
    logic [DIV_WIDTH-1:0]  hcnt_q, hcnt_d, hcnt_cur;
    logic [DATA_WIDTH-1:0] acc_q, acc_d, acc_cur;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] i1_q, i1_d, q1_q, q1_d, i2_q, i2_d, q2_q, q2_d;
    logic                  r1_q, r1_d;
    logic [31:0]           cnt_q, cnt_d;

    logic                  boundary;
    logic                  prbs_step, prbs_reload;
    logic [14:0]           lfsr;
    logic [DATA_WIDTH-1:0] pat_i, pat_q;
    logic [DATA_WIDTH-1:0] neg_i, neg_q;

    assign boundary = (cad_q == 2'd0);
    assign neg_i    = DATA_WIDTH'(sat_neg(32'(signed'(const_i)), DATA_WIDTH));
    assign neg_q    = DATA_WIDTH'(sat_neg(32'(signed'(const_q)), DATA_WIDTH));

    ad9364_prbs15 #(
        .SEED (LFSR_SEED)
    ) u_prbs (
        .clk    (clk),
        .rstn   (rstn),
        .step   (prbs_step),
        .reload (prbs_reload),
        .lfsr   (lfsr)
    );

    always_comb begin
        // The mode latched at the last boundary sets the cadence, so a switch never shortens a sample.
        cad_d       = (r1_q && cad_q == 2'd1) ? 2'd0 : cad_q + 2'd1;
        state_d     = state_q;
        phase_d     = phase_q;
        hcnt_d      = hcnt_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        r1_d        = r1_q;
        valid_d     = 1'b0;
        i1_d        = i1_q;
        q1_d        = q1_q;
        i2_d        = i2_q;
        q2_d        = q2_q;
        prbs_step   = 1'b0;
        prbs_reload = 1'b0;
        pat_i       = '0;
        pat_q       = '0;
        phase_cur   = phase_q;
        hcnt_cur    = hcnt_q;
        acc_cur     = acc_q;

        if (boundary) begin
            valid_d = 1'b1;
            r1_d    = r1_mode;
            state_d = enable ? ST_RUN : ST_IDLE;
            if (enable) begin
                if (state_q == ST_IDLE) begin
                    phase_cur   = 1'b1;
                    hcnt_cur    = '0;
                    acc_cur     = '0;
                    prbs_reload = 1'b1;
                end
                phase_d = phase_cur;
                hcnt_d  = hcnt_cur;
                acc_d   = acc_cur;
                cnt_d   = cnt_q + 32'd1;
                case (pattern_e'(pattern_sel))
                    PAT_CONST: begin
                        pat_i = const_i;
                        pat_q = const_q;
                    end
                    PAT_SQUARE: begin
                        pat_i = phase_cur ? const_i : neg_i;
                        pat_q = phase_cur ? const_q : neg_q;
                        if (hcnt_cur >= half_period) begin
                            hcnt_d  = '0;
                            phase_d = ~phase_cur;
                        end else begin
                            hcnt_d = hcnt_cur + DIV_WIDTH'(1);
                        end
                    end
                    PAT_RAMP: begin
                        pat_i = acc_cur;
                        pat_q = acc_cur + RAMP_OFFSET;
                        acc_d = acc_cur + ramp_step;
                    end
                    PAT_PRBS: begin
                        pat_i     = DATA_WIDTH'(lfsr[11:0]);
                        pat_q     = DATA_WIDTH'(lfsr[14:3]);
                        prbs_step = 1'b1;
                    end
                    default: begin
                        pat_i = '0;
                        pat_q = '0;
                    end
                endcase
            end
            i1_d = pat_i;
            q1_d = pat_q;
            i2_d = r1_mode ? '0 : pat_q;
            q2_d = r1_mode ? '0 : pat_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cad_q   <= 2'd0;
            state_q <= ST_IDLE;
            phase_q <= 1'b1;
            hcnt_q  <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            i1_q    <= '0;
            q1_q    <= '0;
            i2_q    <= '0;
            q2_q    <= '0;
            r1_q    <= 1'b1;
            cnt_q   <= 32'd0;
        end else begin
            cad_q   <= cad_d;
            state_q <= state_d;
            phase_q <= phase_d;
            hcnt_q  <= hcnt_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            i1_q    <= i1_d;
            q1_q    <= q1_d;
            i2_q    <= i2_d;
            q2_q    <= q2_d;
            r1_q    <= r1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dac_valid   = valid_q;
    assign dac_data_i1 = i1_q;
    assign dac_data_q1 = q1_q;
    assign dac_data_i2 = i2_q;
    assign dac_data_q2 = q2_q;
    assign dac_r1_mode = r1_q;
    assign sample_cnt  = cnt_q;

endmodule

// File: tb/tb_ad9364_dac_pattern_gen.sv
// Directed bench for ad9364_dac_pattern_gen: a vector table for pattern/cadence behaviour
// plus hand-written sequences for enable glitches, mode switches, PRBS period and async reset.
module tb_ad9364_dac_pattern_gen;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        r1_mode = 1'b1;
    logic [11:0] const_i = 12'h0;
    logic [11:0] const_q = 12'h0;
    logic [11:0] ramp_step = 12'h0;
    logic [15:0] half_period = 16'h0;
    logic        dac_valid;
    logic [11:0] dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2;
    logic        dac_r1_mode;
    logic [31:0] sample_cnt;

    int n_vec = 0;
    int n_miss = 0;
    int exp_cnt = 0;

    localparam int NVEC = 20;
    localparam int PRBS_PERIOD = 32767;
    localparam int PRBS_KEEP = 40;

    typedef struct {
        logic        en;
        logic [1:0]  sel;
        logic        r1;
        logic [11:0] ci;
        logic [11:0] cq;
        logic [11:0] step;
        logic [15:0] half;
        int          gap;
        logic [11:0] i1;
        logic [11:0] q1;
        logic [11:0] i2;
        logic [11:0] q2;
    } vec_t;

    vec_t vecs[NVEC];

    ad9364_dac_pattern_gen dut (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .r1_mode     (r1_mode),
        .const_i     (const_i),
        .const_q     (const_q),
        .ramp_step   (ramp_step),
        .half_period (half_period),
        .dac_valid   (dac_valid),
        .dac_data_i1 (dac_data_i1),
        .dac_data_q1 (dac_data_q1),
        .dac_data_i2 (dac_data_i2),
        .dac_data_q2 (dac_data_q2),
        .dac_r1_mode (dac_r1_mode),
        .sample_cnt  (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Waits (bounded) for the next dac_valid pulse; gap is the number of clocks it took.
    task automatic next_sample(output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!dac_valid && gap < 20);
    endtask

    task automatic check_sample(input string tag, input int gap, input int egap,
                                input logic [11:0] i1, input logic [11:0] q1,
                                input logic [11:0] i2, input logic [11:0] q2);
        check({tag, " gap"}, 32'(gap), 32'(egap));
        check({tag, " valid"}, 32'(dac_valid), 32'd1);
        check({tag, " i1"}, 32'(dac_data_i1), 32'(i1));
        check({tag, " q1"}, 32'(dac_data_q1), 32'(q1));
        check({tag, " i2"}, 32'(dac_data_i2), 32'(i2));
        check({tag, " q2"}, 32'(dac_data_q2), 32'(q2));
    endtask

    initial begin
        int g;
        int model_err;
        int per_err;
        logic [14:0] m;
        logic [11:0] first_i1[PRBS_KEEP];
        logic [11:0] first_q1[PRBS_KEEP];

        //            en    sel   r1    ci      cq      step    half    gap i1      q1      i2      q2
        vecs[0]  = '{1'b1, 2'd0, 1'b0, 12'h3FF, 12'h800, 12'h000, 16'd0, 2, 12'h3FF, 12'h800, 12'h800, 12'h3FF};
        vecs[1]  = '{1'b1, 2'd0, 1'b0, 12'h3FF, 12'h800, 12'h000, 16'd0, 4, 12'h3FF, 12'h800, 12'h800, 12'h3FF};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 12'h3FF, 12'h800, 12'h000, 16'd0, 4, 12'h3FF, 12'h800, 12'h800, 12'h3FF};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 12'h3FF, 12'h800, 12'h000, 16'd0, 4, 12'h000, 12'h000, 12'h000, 12'h000};
        vecs[4]  = '{1'b1, 2'd1, 1'b1, 12'h800, 12'h3FF, 12'h000, 16'd2, 4, 12'h800, 12'h3FF, 12'h000, 12'h000};
        vecs[5]  = '{1'b1, 2'd1, 1'b1, 12'h800, 12'h3FF, 12'h000, 16'd2, 2, 12'h800, 12'h3FF, 12'h000, 12'h000};
        vecs[6]  = '{1'b1, 2'd1, 1'b1, 12'h800, 12'h3FF, 12'h000, 16'd2, 2, 12'h800, 12'h3FF, 12'h000, 12'h000};
        vecs[7]  = '{1'b1, 2'd1, 1'b1, 12'h800, 12'h3FF, 12'h000, 16'd2, 2, 12'h7FF, 12'hC01, 12'h000, 12'h000};
        vecs[8]  = '{1'b1, 2'd1, 1'b1, 12'h800, 12'h3FF, 12'h000, 16'd2, 2, 12'h7FF, 12'hC01, 12'h000, 12'h000};
        vecs[9]  = '{1'b1, 2'd1, 1'b1, 12'h800, 12'h3FF, 12'h000, 16'd2, 2, 12'h7FF, 12'hC01, 12'h000, 12'h000};
        vecs[10] = '{1'b1, 2'd1, 1'b1, 12'h800, 12'h3FF, 12'h000, 16'd2, 2, 12'h800, 12'h3FF, 12'h000, 12'h000};
        vecs[11] = '{1'b1, 2'd2, 1'b1, 12'h800, 12'h3FF, 12'hFFF, 16'd2, 2, 12'h000, 12'h400, 12'h000, 12'h000};
        vecs[12] = '{1'b1, 2'd2, 1'b1, 12'h800, 12'h3FF, 12'hFFF, 16'd2, 2, 12'hFFF, 12'h3FF, 12'h000, 12'h000};
        vecs[13] = '{1'b1, 2'd2, 1'b1, 12'h800, 12'h3FF, 12'hFFF, 16'd2, 2, 12'hFFE, 12'h3FE, 12'h000, 12'h000};
        vecs[14] = '{1'b1, 2'd1, 1'b1, 12'h800, 12'h3FF, 12'hFFF, 16'd2, 2, 12'h800, 12'h3FF, 12'h000, 12'h000};
        vecs[15] = '{1'b1, 2'd1, 1'b1, 12'h800, 12'h3FF, 12'hFFF, 16'd2, 2, 12'h800, 12'h3FF, 12'h000, 12'h000};
        vecs[16] = '{1'b1, 2'd1, 1'b1, 12'h800, 12'h3FF, 12'hFFF, 16'd2, 2, 12'h7FF, 12'hC01, 12'h000, 12'h000};
        vecs[17] = '{1'b1, 2'd2, 1'b1, 12'h800, 12'h3FF, 12'hFFF, 16'd2, 2, 12'hFFD, 12'h3FD, 12'h000, 12'h000};
        vecs[18] = '{1'b1, 2'd0, 1'b0, 12'h5A5, 12'hA5A, 12'hFFF, 16'd2, 2, 12'h5A5, 12'hA5A, 12'hA5A, 12'h5A5};
        vecs[19] = '{1'b1, 2'd0, 1'b0, 12'h5A5, 12'hA5A, 12'hFFF, 16'd2, 4, 12'h5A5, 12'hA5A, 12'hA5A, 12'h5A5};

        // Reset state while rstn is held low across a clock edge.
        #12;
        check("reset valid", 32'(dac_valid), 32'd0);
        check("reset i1", 32'(dac_data_i1), 32'd0);
        check("reset q2", 32'(dac_data_q2), 32'd0);
        check("reset r1_mode", 32'(dac_r1_mode), 32'd1);
        check("reset cnt", sample_cnt, 32'd0);
        $display("reset: valid=%0d r1=%0d cnt=%0d", dac_valid, dac_r1_mode, sample_cnt);

        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_sample(g);
            check_sample($sformatf("idle%0d", k), g, (k == 0) ? 1 : 2, 12'h0, 12'h0, 12'h0, 12'h0);
            check($sformatf("idle%0d cnt", k), sample_cnt, 32'd0);
            $display("idle sample %0d: gap=%0d i1=%h cnt=%0d", k, g, dac_data_i1, sample_cnt);
        end

        // An enable pulse that falls before the boundary must be ignored.
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        next_sample(g);
        check_sample("glitch", g, 1, 12'h0, 12'h0, 12'h0, 12'h0);
        check("glitch cnt", sample_cnt, 32'd0);
        $display("enable glitch: gap=%0d i1=%h cnt=%0d", g, dac_data_i1, sample_cnt);

        for (int r = 0; r < NVEC; r++) begin
            enable      = vecs[r].en;
            pattern_sel = vecs[r].sel;
            r1_mode     = vecs[r].r1;
            const_i     = vecs[r].ci;
            const_q     = vecs[r].cq;
            ramp_step   = vecs[r].step;
            half_period = vecs[r].half;
            if (vecs[r].en) exp_cnt++;
            next_sample(g);
            check_sample($sformatf("vec%0d", r), g, vecs[r].gap,
                         vecs[r].i1, vecs[r].q1, vecs[r].i2, vecs[r].q2);
            check($sformatf("vec%0d r1_mode", r), 32'(dac_r1_mode), 32'(vecs[r].r1));
            check($sformatf("vec%0d cnt", r), sample_cnt, 32'(exp_cnt));
            $display("vec %0d: sel=%0d en=%0d gap=%0d i1=%h q1=%h i2=%h q2=%h cnt=%0d",
                     r, pattern_sel, enable, g, dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2, sample_cnt);
        end

        // Mode switches: new mode applies at the next boundary only.
        enable = 1'b0;
        r1_mode = 1'b1;
        next_sample(g);
        check("mode r2->r1 gap", 32'(g), 32'd4);
        check("mode r2->r1 latched", 32'(dac_r1_mode), 32'd1);
        next_sample(g);
        check("mode r1 gap", 32'(g), 32'd2);
        r1_mode = 1'b0;
        @(negedge clk);
        r1_mode = 1'b1;
        next_sample(g);
        check("mode glitch gap", 32'(g + 1), 32'd2);
        check("mode glitch latched", 32'(dac_r1_mode), 32'd1);
        r1_mode = 1'b0;
        next_sample(g);
        check("mode r1->r2 gap", 32'(g), 32'd2);
        check("mode r1->r2 latched", 32'(dac_r1_mode), 32'd0);
        next_sample(g);
        check("mode r2 gap", 32'(g), 32'd4);
        r1_mode = 1'b1;
        next_sample(g);
        check("mode back gap", 32'(g), 32'd4);
        next_sample(g);
        check("mode back r1 gap", 32'(g), 32'd2);
        $display("mode switch sequence: r1_mode=%0d last gap=%0d", dac_r1_mode, g);

        // PRBS: check against a polynomial model and verify the 32767-sample period.
        pattern_sel = 2'd3;
        next_sample(g);
        check("prbs idle i1", 32'(dac_data_i1), 32'd0);
        enable = 1'b1;
        model_err = 0;
        per_err = 0;
        m = 15'h7FFF;
        for (int k = 0; k < PRBS_PERIOD + PRBS_KEEP; k++) begin
            next_sample(g);
            if (g != 2 || dac_data_i1 !== m[11:0] || dac_data_q1 !== m[14:3] ||
                dac_data_i2 !== 12'h0 || dac_data_q2 !== 12'h0) model_err++;
            if (k == 0) begin
                check("prbs first i1", 32'(dac_data_i1), 32'h0FFF);
                check("prbs first q1", 32'(dac_data_q1), 32'h0FFF);
            end
            if (k < PRBS_KEEP) begin
                first_i1[k] = dac_data_i1;
                first_q1[k] = dac_data_q1;
            end else if (k >= PRBS_PERIOD) begin
                if (dac_data_i1 !== first_i1[k - PRBS_PERIOD] ||
                    dac_data_q1 !== first_q1[k - PRBS_PERIOD]) per_err++;
            end
            m = {m[13:0], m[14] ^ m[13]};
        end
        exp_cnt += PRBS_PERIOD + PRBS_KEEP;
        check("prbs model errors", 32'(model_err), 32'd0);
        check("prbs period errors", 32'(per_err), 32'd0);
        $display("prbs run: %0d samples, model errors=%0d, period errors=%0d",
                 PRBS_PERIOD + PRBS_KEEP, model_err, per_err);

        enable = 1'b0;
        next_sample(g);
        check("prbs drop i1", 32'(dac_data_i1), 32'd0);
        check("prbs drop cnt", sample_cnt, 32'(exp_cnt));
        enable = 1'b1;
        next_sample(g);
        check("prbs restart i1", 32'(dac_data_i1), 32'h0FFF);
        next_sample(g);
        check("prbs restart2 i1", 32'(dac_data_i1), 32'h0FFE);
        check("prbs restart2 q1", 32'(dac_data_q1), 32'h0FFF);
        $display("prbs restart: i1=%h q1=%h cnt=%0d", dac_data_i1, dac_data_q1, sample_cnt);

        // Asynchronous reset mid-RUN, applied between clock edges.
        pattern_sel = 2'd0;
        const_i = 12'h123;
        const_q = 12'h456;
        next_sample(g);
        next_sample(g);
        check("pre-reset i1", 32'(dac_data_i1), 32'h0123);
        #2;
        rstn = 1'b0;
        #1;
        check("async valid", 32'(dac_valid), 32'd0);
        check("async i1", 32'(dac_data_i1), 32'd0);
        check("async q1", 32'(dac_data_q1), 32'd0);
        check("async cnt", sample_cnt, 32'd0);
        check("async r1_mode", 32'(dac_r1_mode), 32'd1);
        $display("async reset: valid=%0d i1=%h cnt=%0d", dac_valid, dac_data_i1, sample_cnt);
        @(negedge clk);
        rstn = 1'b1;
        next_sample(g);
        check_sample("post-reset", g, 1, 12'h123, 12'h456, 12'h0, 12'h0);
        $display("post reset: gap=%0d i1=%h q1=%h", g, dac_data_i1, dac_data_q1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
